enigma_step_controller: RTL
===========================

Name: enigma_step_controller

Overview:
- Drives stepping of the three-rotor Enigma stack: left, middle and right rotors, each counting 0-25.
- Detects a keypress and decides which rotors advance, using right- and middle-rotor notch positions and the double-step anomaly.
- Issues one-cycle step strobes and keeps shadow copies of all three rotor positions.
- Pulses enc_go once the new positions are stable, so the substitution path encrypts after stepping, as the real machine does.

Parameters:
- NOTCH_R, 21, right-rotor turnover position (rotor III, V->W).
- NOTCH_M, 4, middle-rotor turnover position (rotor II, E->F).
- MAX_POS, 25, highest rotor position; the position after MAX_POS is 0.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- key_press  in  1  level key signal, already synchronous to clk; a rising edge requests one step.
- load_init_state  in  1  synchronous load of the initial positions; has priority over everything except reset.
- init_l, init_m, init_r  in  5 each  initial positions.
- step_l, step_m, step_r  out  1 each  one-cycle increment strobes to the rotors.
- pos_l, pos_m, pos_r  out  5 each  shadow rotor positions.
- enc_go  out  1  one-cycle strobe: positions are updated, encrypt now.
- ready  out  1  high in IDLE; a keypress edge is accepted only while ready is high.

Behaviour:
- Reset (resetn=0, asynchronous):
  - state=IDLE; all strobes 0; pos_*=0; ready=1; key edge register cleared.
- Edge detect:
  - key_q registers key_press every cycle.
  - edge = key_press & ~key_q.
  - An edge seen outside IDLE is dropped; it is neither queued nor counted.
- Load:
  - When load_init_state=1 in any state, on the next clock edge: pos_x = (init_x > MAX_POS) ? 0 : init_x; state goes to IDLE; no strobes are issued.
  - If load and a key edge occur in the same cycle, the load wins and the edge is dropped.
  - A load during STEP or SETTLE aborts the step and suppresses enc_go.
- FSM, three states:
  - IDLE: on edge, go to STEP.
  - STEP, one cycle:
    - step_r=1 always.
    - step_m = (pos_r==NOTCH_R) | dbl, where dbl = (pos_m==NOTCH_M).
    - step_l = (pos_m==NOTCH_M).
    - All decisions use the pre-step positions.
    - On exit, every strobed pos_x increments, wrapping MAX_POS->0.
    - Then go to SETTLE.
  - SETTLE, one cycle: enc_go=1, then go to IDLE.
- Latency:
  - Key rising edge sampled at edge N.
  - Step strobes are high during cycle N+1.
  - Updated pos_* are visible from cycle N+2, while enc_go=1.
  - The next key edge is accepted at edge N+3 at the earliest.
- Width rules:
  - Increment is 5-bit with an explicit compare-and-wrap; no modulo operator.
  - pos_* never exceed MAX_POS.
- Strobe exclusivity:
  - The strobes are never high outside STEP.
  - enc_go is never high in the same cycle as a step strobe.

Optional Feature:
- Macro ENIGMA_DOUBLE_STEP_EN.
- Defined: dbl term active; historical double-step behaviour.
- Undefined: dbl=0. The block is a pure odometer: the middle rotor steps only on right-rotor turnover, and the left steps when the middle is at its notch and is itself stepping, i.e. (pos_r==NOTCH_R)&(pos_m==NOTCH_M).

Decomposition:
- Package enigma_pkg holds:
  - Rotor position typedef (5-bit).
  - MAX_POS.
  - Default notch constants for rotors I-V (Q=16, E=4, V=21, J=9, Z=25).
  - FSM state encoding IDLE/STEP/SETTLE.
- One natural sub-module, enigma_pos_counter: a 5-bit wrap counter with load, clamp-to-0 of out-of-range loads, and increment enable. It is instantiated three times for pos_l, pos_m, pos_r.

Test Plan:
- Reset, then load (0,3,20) and one press -> step_r only; pos=(0,3,21); enc_go one cycle later.
- From (0,3,21), press -> step_r and step_m; pos=(0,4,22).
- From (0,4,22), press with ENIGMA_DOUBLE_STEP_EN defined -> all three strobes; pos=(1,5,23). Without the macro -> step_r only; pos=(0,4,23).
- Load (25,25,25), then press with the right rotor not at its notch -> pos=(25,25,0). Load (7,30,31) -> pos=(7,0,0).
- Key edge one cycle after an accepted edge (during STEP) -> ignored; exactly one step and one enc_go occur.
- Load asserted during STEP -> no enc_go; pos equals the clamped init values. resetn low mid-SETTLE -> enc_go drops immediately and pos=0.

Source files
------------

// File: rtl/enigma_pkg.sv
// Shared rotor-position type, position limit, stock notch positions and step FSM encoding.
package enigma_pkg;

  typedef logic [4:0] rotor_pos_t;

  localparam rotor_pos_t MAX_POS = 5'd25;

  // Turnover positions of the five stock rotors (Q, E, V, J, Z)
  localparam rotor_pos_t NOTCH_I   = 5'd16;
  localparam rotor_pos_t NOTCH_II  = 5'd4;
  localparam rotor_pos_t NOTCH_III = 5'd21;
  localparam rotor_pos_t NOTCH_IV  = 5'd9;
  localparam rotor_pos_t NOTCH_V   = 5'd25;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STEP   = 2'd1,
    ST_SETTLE = 2'd2
  } step_state_e;

  function automatic rotor_pos_t clamp_pos(input rotor_pos_t p, input rotor_pos_t max_p);
    return (p > max_p) ? '0 : p;
  endfunction

endpackage

// File: rtl/enigma_pos_counter.sv
// Single rotor position: 0..WRAP_AT wrap counter with clamped load and increment enable.
module enigma_pos_counter
  import enigma_pkg::*;
#(
  parameter rotor_pos_t WRAP_AT = enigma_pkg::MAX_POS
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  logic [4:0] init_i,
  input  logic       inc_i,
  output logic [4:0] pos_o
);

  rotor_pos_t pos_q;
  rotor_pos_t pos_d;

  function automatic rotor_pos_t wrap_inc(input rotor_pos_t p);
    return (p >= WRAP_AT) ? '0 : p + 5'd1;
  endfunction

  // Load beats increment so an abort during a step leaves the loaded value
  always_comb begin
    pos_d = pos_q;
    if (load_i) begin
      pos_d = clamp_pos(init_i, WRAP_AT);
    end else if (inc_i) begin
      pos_d = wrap_inc(pos_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q <= '0;
    end else begin
      pos_q <= pos_d;
    end
  end

  assign pos_o = pos_q;

endmodule

// File: rtl/enigma_step_controller.sv
// Enigma three-rotor stepping controller; `define ENIGMA_DOUBLE_STEP_EN for the historical
// double-step of the middle rotor, otherwise the stack behaves as a plain odometer.
module enigma_step_controller #(
  parameter logic [4:0] NOTCH_R = enigma_pkg::NOTCH_III,
  parameter logic [4:0] NOTCH_M = enigma_pkg::NOTCH_II,
  parameter logic [4:0] MAX_POS = 5'd25
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       key_press,
  input  logic       load_init_state,
  input  logic [4:0] init_l,
  input  logic [4:0] init_m,
  input  logic [4:0] init_r,
  output logic       step_l,
  output logic       step_m,
  output logic       step_r,
  output logic [4:0] pos_l,
  output logic [4:0] pos_m,
  output logic [4:0] pos_r,
  output logic       enc_go,
  output logic       ready
);

  import enigma_pkg::*;

  step_state_e state_q;
  logic        key_q;
  logic        step_l_q;
  logic        step_m_q;
  logic        step_r_q;
  logic        enc_go_q;
  logic        ready_q;

  logic        key_edge;
  logic        at_notch_r;
  logic        at_notch_m;
  logic        dbl;
  logic        want_step_m;
  logic        want_step_l;

  assign key_edge   = key_press & ~key_q;
  assign at_notch_r = (pos_r == NOTCH_R);
  assign at_notch_m = (pos_m == NOTCH_M);

  always_comb begin
    dbl         = 1'b0;
    want_step_m = 1'b0;
    want_step_l = 1'b0;
`ifdef ENIGMA_DOUBLE_STEP_EN
    dbl         = at_notch_m;
    want_step_l = at_notch_m;
`else
    want_step_l = at_notch_r & at_notch_m;
`endif
    want_step_m = at_notch_r | dbl;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      key_q <= 1'b0;
    end else begin
      key_q <= key_press;
    end
  end

  // Strobe decisions are latched from the pre-step positions on the accepting edge
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      step_l_q <= 1'b0;
      step_m_q <= 1'b0;
      step_r_q <= 1'b0;
      enc_go_q <= 1'b0;
      ready_q  <= 1'b1;
    end else if (load_init_state) begin
      state_q  <= ST_IDLE;
      step_l_q <= 1'b0;
      step_m_q <= 1'b0;
      step_r_q <= 1'b0;
      enc_go_q <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          step_l_q <= 1'b0;
          step_m_q <= 1'b0;
          step_r_q <= 1'b0;
          enc_go_q <= 1'b0;
          if (key_edge) begin
            state_q  <= ST_STEP;
            step_r_q <= 1'b1;
            step_m_q <= want_step_m;
            step_l_q <= want_step_l;
            ready_q  <= 1'b0;
          end else begin
            ready_q  <= 1'b1;
          end
        end
        ST_STEP: begin
          state_q  <= ST_SETTLE;
          step_l_q <= 1'b0;
          step_m_q <= 1'b0;
          step_r_q <= 1'b0;
          enc_go_q <= 1'b1;
          ready_q  <= 1'b0;
        end
        ST_SETTLE: begin
          state_q  <= ST_IDLE;
          enc_go_q <= 1'b0;
          ready_q  <= 1'b1;
        end
        default: begin
          state_q  <= ST_IDLE;
          step_l_q <= 1'b0;
          step_m_q <= 1'b0;
          step_r_q <= 1'b0;
          enc_go_q <= 1'b0;
          ready_q  <= 1'b1;
        end
      endcase
    end
  end

  enigma_pos_counter #(.WRAP_AT(MAX_POS)) u_pos_l (
    .clk    (clk),
    .rst_n  (resetn),
    .load_i (load_init_state),
    .init_i (init_l),
    .inc_i  (step_l_q),
    .pos_o  (pos_l)
  );

  enigma_pos_counter #(.WRAP_AT(MAX_POS)) u_pos_m (
    .clk    (clk),
    .rst_n  (resetn),
    .load_i (load_init_state),
    .init_i (init_m),
    .inc_i  (step_m_q),
    .pos_o  (pos_m)
  );

  enigma_pos_counter #(.WRAP_AT(MAX_POS)) u_pos_r (
    .clk    (clk),
    .rst_n  (resetn),
    .load_i (load_init_state),
    .init_i (init_r),
    .inc_i  (step_r_q),
    .pos_o  (pos_r)
  );

  assign step_l = step_l_q;
  assign step_m = step_m_q;
  assign step_r = step_r_q;
  assign enc_go = enc_go_q;
  assign ready  = ready_q;

endmodule
